// File: rtl/reg_file_mp_pkg.sv
// Shared types and sizing helpers for the multi-port register file and its
// clear sequencer.
package reg_file_mp_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic {
        CLR_IDLE  = 1'b0,
        CLR_CLEAR = 1'b1
    } clr_state_e;

    function automatic int unsigned depth_of(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

    function automatic int unsigned lanes_of(input int unsigned data_width);
        return data_width / BYTE_W;
    endfunction

endpackage

// File: rtl/reg_file_clr_fsm.sv
// Clear sequencer: walks a pointer over every entry, zeroing one per cycle,
// then pulses clr_done as it returns to idle.
module reg_file_clr_fsm
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  zero_en,
    output logic [ADDR_WIDTH-1:0] zero_addr
);

    clr_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  done_q, done_d;

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        done_d  = 1'b0;
        case (state_q)
            CLR_IDLE: begin
                if (clr_start) begin
                    state_d = CLR_CLEAR;
                    ptr_d   = '0;
                end
            end
            CLR_CLEAR: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                // The last entry is the all-ones address; the pointer wraps to 0.
                if (ptr_q == '1) begin
                    state_d = CLR_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = CLR_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= CLR_IDLE;
            ptr_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
        end
    end

    assign clr_busy  = (state_q == CLR_CLEAR);
    assign clr_done  = done_q;
    assign zero_en   = clr_busy;
    assign zero_addr = ptr_q;

endmodule

// File: rtl/reg_file_mp.sv
// Two-read/one-write register file with byte-lane writes, optional registered
// reads, read-during-write bypass and a sequenced full-array clear.
module reg_file_mp
    import reg_file_mp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 2,
    parameter bit          REG_OUT    = 1'b0,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   w_addr,
    input  logic [DATA_WIDTH/8-1:0] w_be,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [ADDR_WIDTH-1:0]   r_addr_a,
    input  logic [ADDR_WIDTH-1:0]   r_addr_b,
    output logic [DATA_WIDTH-1:0]   r_data_a,
    output logic [DATA_WIDTH-1:0]   r_data_b,
    input  logic                    clr_start,
    output logic                    clr_busy,
    output logic                    clr_done,
    output logic                    wr_err
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
    localparam int unsigned LANES = lanes_of(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] merged_d;
    logic [DATA_WIDTH-1:0] rd_a_d, rd_b_d;
    logic                  wr_accept;
    logic                  wr_err_q;
    logic                  zero_en;
    logic [ADDR_WIDTH-1:0] zero_addr;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [LANES-1:0]      be
    );
        logic [DATA_WIDTH-1:0] m;
        m = old_w;
        for (int k = 0; k < int'(LANES); k++) begin
            if (be[k]) m[k*BYTE_W +: BYTE_W] = new_w[k*BYTE_W +: BYTE_W];
        end
        return m;
    endfunction

    reg_file_clr_fsm #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clr_fsm (
        .clk      (clk),
        .reset    (reset),
        .clr_start(clr_start),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .zero_en  (zero_en),
        .zero_addr(zero_addr)
    );

    always_comb begin
        wr_accept = wr_en && !clr_busy;
        merged_d  = merge_lanes(mem_q[w_addr], w_data, w_be);
        rd_a_d    = (BYPASS && wr_accept && (r_addr_a == w_addr)) ? merged_d : mem_q[r_addr_a];
        rd_b_d    = (BYPASS && wr_accept && (r_addr_b == w_addr)) ? merged_d : mem_q[r_addr_b];
    end

    // NOTE: the array is reset explicitly because its contents are architecturally zero after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (zero_en) begin
            mem_q[zero_addr] <= '0;
        end else if (wr_accept) begin
            mem_q[w_addr] <= merged_d;
        end
    end

    // A write arriving while the clear owns the array is dropped and flagged.
    always_ff @(posedge clk) begin
        if (!reset) wr_err_q <= 1'b0;
        else        wr_err_q <= wr_en && clr_busy;
    end

    assign wr_err = wr_err_q;

    if (REG_OUT) begin : g_reg_out
        logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;
        always_ff @(posedge clk) begin
            if (!reset) begin
                rd_a_q <= '0;
                rd_b_q <= '0;
            end else begin
                rd_a_q <= rd_a_d;
                rd_b_q <= rd_b_d;
            end
        end
        assign r_data_a = rd_a_q;
        assign r_data_b = rd_b_q;
    end else begin : g_comb_out
        assign r_data_a = rd_a_d;
        assign r_data_b = rd_b_d;
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: three instances share stimulus to cover the
// combinational, registered-bypass and registered-no-bypass read variants.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [1:0]  w_addr;
    logic [1:0]  w_be;
    logic [15:0] w_data;
    logic [1:0]  r_addr_a, r_addr_b;
    logic        clr_start;

    logic [15:0] c_rda, c_rdb, r_rda, r_rdb, n_rda, n_rdb;
    logic        c_busy, c_done, c_err;
    logic        r_busy, r_done, r_err;
    logic        n_busy, n_done, n_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .REG_OUT(1'b0), .BYPASS(1'b1)) u_comb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(c_rda), .r_data_b(c_rdb),
        .clr_start(clr_start), .clr_busy(c_busy), .clr_done(c_done), .wr_err(c_err));

    reg_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .REG_OUT(1'b1), .BYPASS(1'b1)) u_reg (
        .clk(clk), .reset(reset), .wr_en(wr_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(r_rda), .r_data_b(r_rdb),
        .clr_start(clr_start), .clr_busy(r_busy), .clr_done(r_done), .wr_err(r_err));

    reg_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(2), .REG_OUT(1'b1), .BYPASS(1'b0)) u_reg_nb (
        .clk(clk), .reset(reset), .wr_en(wr_en), .w_addr(w_addr), .w_be(w_be), .w_data(w_data),
        .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .r_data_a(n_rda), .r_data_b(n_rdb),
        .clr_start(clr_start), .clr_busy(n_busy), .clr_done(n_done), .wr_err(n_err));

    // Inputs change 1ns after the rising edge, well clear of the sampling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [1:0] a, input logic [1:0] be, input logic [15:0] d);
        wr_en = 1'b1; w_addr = a; w_be = be; w_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic set_read(input logic [1:0] a);
        r_addr_a = a;
        r_addr_b = a;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; wr_en = 1'b1; w_addr = 2'd1; w_be = 2'b11; w_data = 16'hFFFF;
        clr_start = 1'b0; r_addr_a = 2'd0; r_addr_b = 2'd0;
        step();
        step();
        reset = 1'b1; wr_en = 1'b0;
        checks++;
        if (r_rda !== 16'h0000) begin errors++; $display("FAIL reset_reg_out: got %h expected 0000", r_rda); end
        for (int i = 0; i < 4; i++) begin
            set_read(2'(i));
            checks++;
            if (c_rda !== 16'h0000 || c_rdb !== 16'h0000) begin
                errors++; $display("FAIL reset_entry%0d: got %h/%h expected 0000", i, c_rda, c_rdb);
            end
        end
        checks++;
        if (c_busy !== 1'b0 || c_done !== 1'b0 || c_err !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got busy=%b done=%b err=%b expected 000", c_busy, c_done, c_err);
        end
    endtask

    task automatic test_byte_lane();
        do_write(2'd1, 2'b11, 16'hABCD);
        do_write(2'd1, 2'b01, 16'h1234);
        set_read(2'd1);
        checks++;
        if (c_rda !== 16'hAB34 || c_rdb !== 16'hAB34) begin
            errors++; $display("FAIL byte_lane_comb: got %h/%h expected AB34", c_rda, c_rdb);
        end
        step();
        checks++;
        if (r_rda !== 16'hAB34 || r_rdb !== 16'hAB34 || n_rda !== 16'hAB34) begin
            errors++; $display("FAIL byte_lane_reg: got %h/%h/%h expected AB34", r_rda, r_rdb, n_rda);
        end
    endtask

    task automatic test_bypass();
        do_write(2'd2, 2'b11, 16'h5555);
        wr_en = 1'b1; w_addr = 2'd2; w_be = 2'b10; w_data = 16'hAAAA;
        set_read(2'd2);
        checks++;
        if (c_rda !== 16'hAA55) begin errors++; $display("FAIL bypass_comb: got %h expected AA55", c_rda); end
        step();
        wr_en = 1'b0;
        checks++;
        if (r_rda !== 16'hAA55) begin errors++; $display("FAIL bypass_reg: got %h expected AA55", r_rda); end
        checks++;
        if (n_rda !== 16'h5555) begin errors++; $display("FAIL no_bypass_reg: got %h expected 5555", n_rda); end
        step();
        checks++;
        if (n_rda !== 16'hAA55) begin errors++; $display("FAIL no_bypass_later: got %h expected AA55", n_rda); end
        do_write(2'd2, 2'b00, 16'hFFFF);
        checks++;
        if (c_err !== 1'b0 || c_rda !== 16'hAA55) begin
            errors++; $display("FAIL be_zero_noop: got err=%b data=%h expected 0/AA55", c_err, c_rda);
        end
    endtask

    task automatic test_clear();
        int busy_cnt;
        int done_cnt;
        for (int i = 0; i < 4; i++) do_write(2'(i), 2'b11, 16'(16'h1111 * (i + 1)));
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        wr_en = 1'b1; w_addr = 2'd3; w_be = 2'b11; w_data = 16'hBEEF;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 1) begin
                wr_en = 1'b0;
                checks++;
                if (c_err !== 1'b1) begin errors++; $display("FAIL clr_wr_err: got %b expected 1", c_err); end
                r_addr_a = 2'd0; r_addr_b = 2'd1; #1;
                checks++;
                if (c_rda !== 16'h0000 || c_rdb !== 16'h2222) begin
                    errors++; $display("FAIL clr_partial: got %h/%h expected 0000/2222", c_rda, c_rdb);
                end
            end
            if (c == 2) begin
                set_read(2'd3);
                checks++;
                if (c_err !== 1'b0 || c_rda !== 16'h4444) begin
                    errors++; $display("FAIL clr_drop: got err=%b data=%h expected 0/4444", c_err, c_rda);
                end
            end
            if (c_busy === 1'b1) busy_cnt++;
            if (c_done === 1'b1) begin
                done_cnt++;
                checks++;
                if (c_busy !== 1'b0) begin errors++; $display("FAIL clr_done_busy: got busy=%b expected 0", c_busy); end
            end
            step();
        end
        checks++;
        if (busy_cnt != 4 || done_cnt != 1) begin
            errors++; $display("FAIL clr_timing: got busy=%0d done=%0d expected 4/1", busy_cnt, done_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            set_read(2'(i));
            checks++;
            if (c_rda !== 16'h0000) begin errors++; $display("FAIL clr_entry%0d: got %h expected 0000", i, c_rda); end
        end
    endtask

    task automatic test_reset_mid_clear();
        for (int i = 0; i < 4; i++) do_write(2'(i), 2'b11, 16'h0F0F);
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        checks++;
        if (c_busy !== 1'b0 || c_done !== 1'b0 || r_rda !== 16'h0000) begin
            errors++; $display("FAIL rst_mid_clear: got busy=%b done=%b rd=%h expected 0/0/0000", c_busy, c_done, r_rda);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (c_done !== 1'b0 || c_busy !== 1'b0) begin
                errors++; $display("FAIL rst_mid_clear_after%0d: got busy=%b done=%b expected 0/0", c, c_busy, c_done);
            end
        end
        for (int i = 0; i < 4; i++) begin
            set_read(2'(i));
            checks++;
            if (c_rda !== 16'h0000) begin errors++; $display("FAIL rst_mid_entry%0d: got %h expected 0000", i, c_rda); end
        end
    endtask

    task automatic test_back_to_back_clear();
        int busy_cnt;
        int done_cnt;
        wr_en = 1'b1; w_addr = 2'd2; w_be = 2'b11; w_data = 16'h7777; clr_start = 1'b1;
        step();
        wr_en = 1'b0; clr_start = 1'b0;
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (c == 0) begin
                set_read(2'd2);
                checks++;
                if (c_rda !== 16'h7777 || c_err !== 1'b0) begin
                    errors++; $display("FAIL wr_with_clr: got data=%h err=%b expected 7777/0", c_rda, c_err);
                end
            end
            clr_start = (c == 1);
            if (c_busy === 1'b1) busy_cnt++;
            if (c_done === 1'b1) done_cnt++;
            step();
        end
        clr_start = 1'b0;
        checks++;
        if (busy_cnt != 4 || done_cnt != 1) begin
            errors++; $display("FAIL clr_restart: got busy=%0d done=%0d expected 4/1", busy_cnt, done_cnt);
        end
        set_read(2'd2);
        checks++;
        if (c_rda !== 16'h0000) begin errors++; $display("FAIL wr_with_clr_zeroed: got %h expected 0000", c_rda); end
    endtask

    initial begin
        test_reset();
        test_byte_lane();
        test_bypass();
        test_clear();
        test_reset_mid_clear();
        test_back_to_back_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised two-read/one-write register file. It adds byte-lane write enables, an optional registered read stage, read-during-write bypass and a multi-cycle clear sequencer. It serves as the general storage block for datapath and control units that need two operands per cycle, such as ALU operand fetch and UART/timer configuration banks. Replaces single-port register files in new designs.

## Interface
- DATA_WIDTH, 16: word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 2: address bits; DEPTH = 2**ADDR_WIDTH entries.
- REG_OUT, 0: 0 = combinational read; 1 = read data registered (1-cycle latency).
- BYPASS, 1: 1 = a read hitting the address written in the same cycle returns the merged new word.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous reset, active-low: sampled on rising clk, effective when 0.
- wr_en  input  1  write request.
- w_addr  input  ADDR_WIDTH  write address.
- w_be  input  DATA_WIDTH/8  byte-lane enables; bit k controls w_data[8k+7:8k].
- w_data  input  DATA_WIDTH  write data.
- r_addr_a, r_addr_b  input  ADDR_WIDTH  read addresses, ports A and B.
- r_data_a, r_data_b  output  DATA_WIDTH  read data, ports A and B.
- clr_start  input  1  request a full-array clear.
- clr_busy  output  1  clear sequence in progress.
- clr_done  output  1  one-cycle pulse when the clear completes.
- wr_err  output  1  one-cycle pulse: a write was dropped because a clear was in progress.

## Operation
- Reset (reset=0 at an edge):
  - All entries become 0.
  - FSM goes to IDLE.
  - clr_busy, clr_done and wr_err become 0.
  - Registered r_data_a/b become 0.
  - Reset overrides any write or clear in the same cycle, including a clear mid-sequence.
- Write: in IDLE with wr_en=1, each byte lane k with w_be[k]=1 is updated from w_data. Lanes with w_be[k]=0 keep their value. w_be=0 is a legal no-op and raises no error.
- Reads: both ports are independent. They may use the same address as each other or as w_addr.
- Bypass (BYPASS=1): if r_addr_x == w_addr and the write is accepted that cycle, port x returns the merged word (new enabled lanes, old lanes otherwise).
  - REG_OUT=0: merged word appears the same cycle.
  - REG_OUT=1: merged word is captured into the output register.
- No bypass (BYPASS=0): same-cycle reads return the pre-write contents.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR: clr_start=1. Clear pointer loads 0.
  - In CLEAR, each cycle the entry at the pointer is zeroed and the pointer increments.
  - CLEAR → IDLE: after entry DEPTH-1 is zeroed. The pointer wraps to 0.
  - clr_start while in CLEAR is ignored; there is no restart.
- Write during CLEAR is dropped; wr_err pulses one cycle later. A write with clr_start in the same IDLE cycle commits, then is overwritten by the clear.
- Reads during CLEAR return the current array contents. Entries already cleared read 0; later entries read their old values. Bypass never applies to zeroing.

## Timing
- Read latency: 0 cycles (REG_OUT=0) or 1 cycle (REG_OUT=1).
- Write latency: a value is visible to a non-bypassed read one cycle after the write edge.
- Clear timing, with clr_start sampled at edge T:
  - clr_busy is high from T+1 through T+DEPTH.
  - Entry i is zeroed at edge T+1+i.
  - At T+DEPTH+1, clr_busy falls and clr_done is high for exactly that one cycle.
- wr_err is high for the cycle following the dropped write.
- Back-to-back writes to the same address: the last one wins, lane-wise.

## Structure
- Package reg_file_mp_pkg holds:
  - the clear-FSM state enum (IDLE, CLEAR);
  - a DEPTH helper function;
  - the lane-count constant DATA_WIDTH/8.
- Sub-module reg_file_clr_fsm holds the clear sequencer: FSM, pointer, busy/done. It drives a zeroing address and strobe into the array.
- The array, lane merge, bypass mux and optional output register stay in reg_file_mp.

## Test plan
All scenarios use DATA_WIDTH=16, ADDR_WIDTH=2.
- Reset then read, REG_OUT=0: hold reset=0 for 2 cycles with wr_en=1 → all four entries read 0x0000; clr_busy=0.
- Byte-lane write: write 0xABCD to addr 1 with w_be=2'b11, then 0x1234 with w_be=2'b01 → addr 1 reads 0xAB34 on both ports.
- Bypass, REG_OUT=1, BYPASS=1: addr 2 holds 0x5555; write 0xAAAA, w_be=2'b10, while r_addr_a=2 → r_data_a=0xAA55 the next cycle.
  - Same stimulus with BYPASS=0 → r_data_a=0x5555.
- Clear: fill entries with 0x1111–0x4444, pulse clr_start → clr_busy high for 4 cycles, clr_done pulses once. A write to addr 3 during busy is dropped and wr_err pulses. Afterwards all entries read 0x0000.
- Reset mid-clear: reset=0 during the 2nd CLEAR cycle → next cycle clr_busy=0, clr_done stays 0, all entries 0.
- Simultaneous write and clr_start in IDLE: write commits, then the clear zeroes it; a clr_start during CLEAR is ignored (busy stays exactly 4 cycles).
